// File: rtl/run_monitor.sv
// run_monitor: counts CPU run cycles, samples PC periodically, flags halt (PC stuck) or cycle-budget timeout.
`timescale 1ns/1ps
module run_monitor #(
    parameter int PC_W         = 32,
    parameter int CNT_W        = 32,
    parameter int SAMPLE_EVERY = 10,
    parameter int MAX_CYCLES   = 500,
    parameter int STALL_LIMIT  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run_en,
    input  logic             clear,
    input  logic [PC_W-1:0]  pc_in,
    input  logic             pc_valid,
    output logic             sample_valid,
    output logic [PC_W-1:0]  sample_pc,
    output logic [CNT_W-1:0] sample_cycle,
    output logic [CNT_W-1:0] cycle_count,
    output logic [1:0]       state,
    output logic             done,
    output logic             timeout,
    output logic             halted
);
    typedef enum logic [1:0] {IDLE, RUN, HALTED, TIMEOUT} state_t;
    localparam int PH_W = $clog2(SAMPLE_EVERY + 1);
    localparam int ST_W = $clog2(STALL_LIMIT + 1);
    localparam logic [PH_W-1:0]  PH_LAST = PH_W'(SAMPLE_EVERY - 1);
    localparam logic [ST_W-1:0]  ST_LIM  = ST_W'(STALL_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_CYCLES);
    state_t           st, st_n;
    logic [CNT_W-1:0] cnt_n, scyc_n;
    logic [PH_W-1:0]  phase, ph_n;
    logic [ST_W-1:0]  stall_cnt, stall_n;
    logic [PC_W-1:0]  last_pc, last_n, spc_n;
    logic             sv_n;
    assign state   = st;
    assign done    = st == HALTED || st == TIMEOUT;
    assign halted  = st == HALTED;
    assign timeout = st == TIMEOUT;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st           <= IDLE;
            cycle_count  <= '0;
            phase        <= '0;
            stall_cnt    <= '0;
            last_pc      <= '0;
            sample_pc    <= '0;
            sample_cycle <= '0;
            sample_valid <= 1'b0;
        end else begin
            st           <= st_n;
            cycle_count  <= cnt_n;
            phase        <= ph_n;
            stall_cnt    <= stall_n;
            last_pc      <= last_n;
            sample_pc    <= spc_n;
            sample_cycle <= scyc_n;
            sample_valid <= sv_n;
        end
    end
    // The IDLE->RUN edge is itself run cycle 1, so it shares the RUN update path.
    always_comb begin
        st_n    = st;
        cnt_n   = cycle_count;
        ph_n    = phase;
        stall_n = stall_cnt;
        last_n  = last_pc;
        spc_n   = sample_pc;
        scyc_n  = sample_cycle;
        sv_n    = 1'b0;
        if (clear) begin
            st_n    = IDLE;
            cnt_n   = '0;
            ph_n    = '0;
            stall_n = '0;
            last_n  = '0;
            spc_n   = '0;
            scyc_n  = '0;
        end else if (run_en && (st == IDLE || st == RUN)) begin
            cnt_n = cycle_count + 1'b1;
            sv_n  = phase == PH_LAST;
            ph_n  = sv_n ? '0 : phase + 1'b1;
            if (sv_n) begin
                spc_n  = pc_in;
                scyc_n = cnt_n;
            end
            if (pc_valid) begin
                stall_n = pc_in != last_pc ? ST_W'(1) : stall_cnt == ST_LIM ? stall_cnt : stall_cnt + 1'b1;
                last_n  = pc_in;
            end
            st_n = stall_n == ST_LIM ? HALTED : cnt_n == CNT_MAX ? TIMEOUT : RUN;
        end
    end
endmodule

// File: tb/tb_run_monitor.sv
// tb_run_monitor: directed run_monitor bench; reference model predicts state/count and queues expected samples.
`timescale 1ns/1ps
module tb_run_monitor;
    typedef struct {logic [31:0] pc; logic [31:0] cyc;} smp_t;
    logic clk = 0, rst_n = 0, run_en = 0, clear = 0, pc_valid = 0;
    logic [31:0] pc_in = 0;
    logic sv1, done1, to1, h1, sv2, done2, to2, h2;
    logic [31:0] spc1, scyc1, cnt1, spc2, scyc2, cnt2;
    logic [1:0] st1, st2;
    int n_chk = 0, n_fail = 0, n_smp = 0;
    int m_state = 0, m_cnt = 0, m_stall = 0;
    logic [31:0] m_last = 0;
    smp_t q[$];

    run_monitor u1 (.clk(clk), .rst_n(rst_n), .run_en(run_en), .clear(clear), .pc_in(pc_in),
        .pc_valid(pc_valid), .sample_valid(sv1), .sample_pc(spc1), .sample_cycle(scyc1),
        .cycle_count(cnt1), .state(st1), .done(done1), .timeout(to1), .halted(h1));
    run_monitor #(.MAX_CYCLES(32)) u2 (.clk(clk), .rst_n(rst_n), .run_en(run_en), .clear(clear),
        .pc_in(pc_in), .pc_valid(pc_valid), .sample_valid(sv2), .sample_pc(spc2),
        .sample_cycle(scyc2), .cycle_count(cnt2), .state(st2), .done(done2), .timeout(to2),
        .halted(h2));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_cnt = 0;
        m_stall = 0;
        m_last = 0;
        q.delete();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_sv"}, sv1, 0);
        chk({tag, "_spc"}, spc1, 0);
        chk({tag, "_scyc"}, scyc1, 0);
        chk({tag, "_cnt"}, cnt1, 0);
        chk({tag, "_state"}, st1, 0);
        chk({tag, "_done"}, done1, 0);
        chk({tag, "_timeout"}, to1, 0);
        chk({tag, "_halted"}, h1, 0);
    endtask

    // Predict the edge from the inputs now applied, then check the DUT after it.
    task automatic tick();
        smp_t s;
        if (clear) begin
            m_state = 0;
            m_cnt = 0;
            m_stall = 0;
            m_last = 0;
        end else if (run_en && m_state < 2) begin
            m_cnt++;
            if (m_cnt % 10 == 0) q.push_back('{pc_in, 32'(m_cnt)});
            if (pc_valid) begin
                m_stall = (pc_in == m_last) ? ((m_stall < 16) ? m_stall + 1 : 16) : 1;
                m_last = pc_in;
            end
            m_state = (m_stall == 16) ? 2 : (m_cnt == 500) ? 3 : 1;
        end
        @(posedge clk);
        #1;
        chk("state", st1, m_state);
        chk("cycle_count", cnt1, m_cnt);
        chk("done", done1, m_state >= 2);
        chk("halted", h1, m_state == 2);
        chk("timeout", to1, m_state == 3);
        if (sv1) begin
            n_smp++;
            chk("sample_expected", q.size() > 0, 1);
            if (q.size() > 0) begin
                s = q.pop_front();
                chk("sample_pc", spc1, s.pc);
                chk("sample_cycle", scyc1, s.cyc);
            end
        end
        chk("sample_missing", q.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        #12;
        chk_zero("reset");
        chk("u2_reset_state", st2, 0);
        @(negedge clk);
        rst_n = 1;
        run_en = 1;
        pc_valid = 1;
        // Incrementing PC, then stuck at 0x40 from cycle 25: halt at 40, then hold.
        for (int c = 1; c <= 60; c++) begin
            pc_in = (c < 25) ? 32'(4 * (c - 1)) : 32'h40;
            tick();
        end
        chk("halt_cycle", cnt1, 40);
        chk("halt_flag", h1, 1);
        // Clear out of HALTED, then restart from cycle 1.
        clear = 1;
        run_en = 0;
        tick();
        chk("clear_state", st1, 0);
        clear = 0;
        run_en = 1;
        for (int c = 1; c <= 37; c++) begin
            pc_in = 32'h1000 + 32'(4 * c);
            tick();
            if (c == 1) chk("restart_cnt", cnt1, 1);
        end
        // Asynchronous reset mid-cycle.
        #2;
        rst_n = 0;
        #1;
        chk_zero("async_reset");
        model_reset();
        @(negedge clk);
        rst_n = 1;
        n_smp = 0;
        // Freeze for 7 cycles at cycle 13, then run to timeout.
        for (int c = 1; c <= 13; c++) begin
            pc_in = 32'h8000 + 32'(4 * c);
            tick();
        end
        run_en = 0;
        pc_valid = 0;
        pc_in = 32'h8000;
        repeat (7) tick();
        chk("freeze_cnt", cnt1, 13);
        chk("freeze_stall", u1.stall_cnt, m_stall);
        run_en = 1;
        pc_valid = 1;
        for (int c = 14; c <= 500; c++) begin
            pc_in = 32'h8000 + 32'(4 * c);
            tick();
        end
        chk("timeout_flag", to1, 1);
        chk("timeout_cnt", cnt1, 500);
        chk("n_samples", n_smp, 50);
        repeat (5) tick();
        chk("timeout_hold", cnt1, 500);
        // Halt and timeout on the same edge: HALTED wins (u2 budget is 32).
        rst_n = 0;
        model_reset();
        @(negedge clk);
        rst_n = 1;
        for (int c = 1; c <= 32; c++) begin
            pc_in = (c < 17) ? 32'h2000 + 32'(4 * c) : 32'h3000;
            tick();
        end
        chk("u2_state", st2, 2);
        chk("u2_timeout", to2, 0);
        chk("u2_halted", h2, 1);
        chk("u2_done", done2, 1);
        chk("u2_cnt", cnt2, 32);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
